// File: rtl/clock_divider_prog_if.sv
// Bus bundle for clock_divider_prog.
// Build option: TICK_COUNT_EN adds the tick_count signal.
// master : control side; drives en/clr/div_load/div_in and observes the outputs
// slave  : divider side; drives div_cur/tick/clk_out (and tick_count)
interface clock_divider_prog_if #(
  parameter int unsigned DIV_WIDTH = 25,
  parameter int unsigned CNT_WIDTH = 16
);

  logic                 en;
  logic                 clr;
  logic                 div_load;
  logic [DIV_WIDTH-1:0] div_in;
  logic [DIV_WIDTH-1:0] div_cur;
  logic                 tick;
  logic                 clk_out;
`ifdef TICK_COUNT_EN
  logic [CNT_WIDTH-1:0] tick_count;
`endif

  // Reject degenerate widths at elaboration
  if (DIV_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_width
    $error("clock_divider_prog_if: widths must be at least 1");
  end

  modport master (
    output en, clr, div_load, div_in,
    input  div_cur, tick, clk_out
`ifdef TICK_COUNT_EN
    , input tick_count
`endif
  );

  modport slave (
    input  en, clr, div_load, div_in,
    output div_cur, tick, clk_out
`ifdef TICK_COUNT_EN
    , output tick_count
`endif
  );

endinterface

// File: rtl/clock_divider_prog.sv
// Runtime-programmable tick / square-wave divider.
// Counts clk cycles and, every div_cur cycles, emits a one-cycle tick and
// toggles clk_out. A new divisor loaded while counting is held pending and
// takes effect at the next terminal count, so no period is ever shortened.
// Outputs are clk-domain enables, never clocks.
// Build option: define TICK_COUNT_EN to add the tick_count register/port.
// Ports:
//   clk          system clock, posedge
//   rst          synchronous active-low reset
//   bus.en       1 = count, 0 = freeze counter/clk_out/tick_count
//   bus.clr      synchronous clear of counter and outputs (divisor kept)
//   bus.div_load one-cycle strobe to load div_in (0 clamps to 1)
//   bus.div_in   requested divisor
//   bus.div_cur  divisor in effect
//   bus.tick     one-cycle pulse per terminal count
//   bus.clk_out  toggles per terminal count (period 2*div_cur)
//   bus.tick_count ticks since reset/clr, wraps (TICK_COUNT_EN only)
module clock_divider_prog #(
  parameter int unsigned DIV_WIDTH   = 25,
  parameter int unsigned DEFAULT_DIV = 25_000_000,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  clock_divider_prog_if.slave bus
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(DEFAULT_DIV);

  // Elaboration-time parameter sanity
  if (DIV_WIDTH < 1 || DIV_WIDTH > 32) begin : g_bad_div_width
    $error("clock_divider_prog: DIV_WIDTH must be 1..32");
  end
  if (DEFAULT_DIV < 1 || 64'(DEFAULT_DIV) >= (64'(1) << DIV_WIDTH)) begin : g_bad_default
    $error("clock_divider_prog: DEFAULT_DIV out of range");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("clock_divider_prog: CNT_WIDTH must be at least 1");
  end

  logic [DIV_WIDTH-1:0] cnt_q,     cnt_d;
  logic [DIV_WIDTH-1:0] div_q,     div_d;
  logic [DIV_WIDTH-1:0] pend_q,    pend_d;
  logic                 pend_vld_q, pend_vld_d;
  logic                 tick_q,    tick_d;
  logic                 clk_out_q, clk_out_d;
`ifdef TICK_COUNT_EN
  logic [CNT_WIDTH-1:0] tcnt_q,    tcnt_d;
`endif

  logic [DIV_WIDTH-1:0] div_in_clamped_c;
  logic                 tc_c;

  // Zero divisor is meaningless; treat as divide-by-one
  always_comb begin
    div_in_clamped_c = bus.div_in;
    if (bus.div_in == '0) begin
      div_in_clamped_c = DIV_ONE;
    end
  end

  // div_q is never 0, so the subtraction cannot wrap
  always_comb begin
    tc_c = bus.en && (cnt_q == (div_q - DIV_ONE));
  end

  // Next-state logic; priority clr > load/count
  always_comb begin
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tick_d     = 1'b0;
    clk_out_d  = clk_out_q;
`ifdef TICK_COUNT_EN
    tcnt_d     = tcnt_q;
`endif

    if (bus.clr) begin
      // Divisor and pending load survive a clear; a same-cycle load is dropped
      cnt_d     = '0;
      clk_out_d = 1'b0;
`ifdef TICK_COUNT_EN
      tcnt_d    = '0;
`endif
    end else if (bus.en) begin
      if (tc_c) begin
        cnt_d     = '0;
        tick_d    = 1'b1;
        clk_out_d = ~clk_out_q;
`ifdef TICK_COUNT_EN
        tcnt_d    = tcnt_q + CNT_WIDTH'(1);
`endif
        // A load landing on the terminal count wins over any pending value
        if (bus.div_load) begin
          div_d = div_in_clamped_c;
        end else if (pend_vld_q) begin
          div_d = pend_q;
        end
        pend_vld_d = 1'b0;
      end else begin
        cnt_d = cnt_q + DIV_ONE;
        // Defer the new divisor so the running period completes unchanged
        if (bus.div_load) begin
          pend_d     = div_in_clamped_c;
          pend_vld_d = 1'b1;
        end
      end
    end else if (bus.div_load) begin
      // Frozen: apply immediately and restart the period
      div_d      = div_in_clamped_c;
      cnt_d      = '0;
      pend_vld_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      div_q      <= DIV_RESET;
      pend_q     <= DIV_RESET;
      pend_vld_q <= 1'b0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
`ifdef TICK_COUNT_EN
      tcnt_q     <= '0;
`endif
    end else begin
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
`ifdef TICK_COUNT_EN
      tcnt_q     <= tcnt_d;
`endif
    end
  end

  assign bus.div_cur = div_q;
  assign bus.tick    = tick_q;
  assign bus.clk_out = clk_out_q;
`ifdef TICK_COUNT_EN
  assign bus.tick_count = tcnt_q;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: a reference model pushes the
// expected outputs for each driven cycle into a scoreboard queue, which is
// popped and compared after the clock edge. Directed checks pin down the
// documented tick/clk_out timing with absolute constants.
module tb_clock_divider_prog;

  localparam int unsigned DW  = 8;
  localparam int unsigned CW  = 2;
  localparam int unsigned DEF = 4;

  typedef struct {
    logic          tick;
    logic          clk_out;
    logic [DW-1:0] div_cur;
    logic [CW-1:0] tcount;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  // Reference model state
  logic [DW-1:0] m_cnt, m_div, m_pend;
  logic          m_pv, m_tick, m_clk;
  logic [CW-1:0] m_tcnt;

  clock_divider_prog_if #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  clock_divider_prog #(
    .DIV_WIDTH  (DW),
    .DEFAULT_DIV(DEF),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic c,
                       input logic l, input logic [DW-1:0] d);
    logic [DW-1:0] dv;
    dv = (d == '0) ? DW'(1) : d;
    if (!r) begin
      m_cnt = '0; m_tick = 1'b0; m_clk = 1'b0; m_div = DW'(DEF);
      m_pv = 1'b0; m_tcnt = '0;
    end else if (c) begin
      m_cnt = '0; m_tick = 1'b0; m_clk = 1'b0; m_tcnt = '0;
    end else if (e) begin
      if (m_cnt == m_div - DW'(1)) begin
        m_cnt  = '0;
        m_tick = 1'b1;
        m_clk  = ~m_clk;
        m_tcnt = m_tcnt + CW'(1);
        if (l) m_div = dv;
        else if (m_pv) m_div = m_pend;
        m_pv = 1'b0;
      end else begin
        m_cnt  = m_cnt + DW'(1);
        m_tick = 1'b0;
        if (l) begin
          m_pend = dv;
          m_pv   = 1'b1;
        end
      end
    end else begin
      m_tick = 1'b0;
      if (l) begin
        m_div = dv;
        m_cnt = '0;
        m_pv  = 1'b0;
      end
    end
  endtask

  // Drive one cycle, predict, then compare after the edge
  task automatic step(input logic r, input logic e, input logic c,
                      input logic l, input logic [DW-1:0] d);
    exp_t x;
    rst          = r;
    bus.en       = e;
    bus.clr      = c;
    bus.div_load = l;
    bus.div_in   = d;
    model(r, e, c, l, d);
    x.tick = m_tick; x.clk_out = m_clk; x.div_cur = m_div; x.tcount = m_tcnt;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("sb_tick", 32'(bus.tick), 32'(x.tick));
    check("sb_clk_out", 32'(bus.clk_out), 32'(x.clk_out));
    check("sb_div_cur", 32'(bus.div_cur), 32'(x.div_cur));
`ifdef TICK_COUNT_EN
    check("sb_tick_count", 32'(bus.tick_count), 32'(x.tcount));
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    logic [11:0] tv, cv;
    logic [7:0]  t2;
    logic [5:0]  t3;
    logic        hold_clk;
    int          nt;
    n_checks = 0;
    n_fail   = 0;
    m_pend   = '0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rst_tick", 32'(bus.tick), 32'd0);
    check("rst_clk_out", 32'(bus.clk_out), 32'd0);
    check("rst_div_cur", 32'(bus.div_cur), 32'(DEF));

    // Divide by 4: ticks at cycles 4,8,12; clk_out high for 4..7 and from 12
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      tv[c] = bus.tick;
      cv[c] = bus.clk_out;
    end
    check("t1_tick_pattern", 32'(tv), 32'h888);
    check("t1_clk_pattern", 32'(cv), 32'h878);

    // Mid-period load of 2 completes the old period first
    run(1);
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b1, 1'b0, (c == 0), DW'(2));
      t2[c] = bus.tick;
      if (c == 1) check("t2_div_before_tc", 32'(bus.div_cur), 32'd4);
      if (c == 2) check("t2_div_after_tc", 32'(bus.div_cur), 32'd2);
    end
    check("t2_tick_pattern", 32'(t2), 32'h54);

    // Load 0 while frozen: clamps to 1, tick every cycle
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    check("t3_div_clamped", 32'(bus.div_cur), 32'd1);
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      t3[c] = bus.tick;
    end
    check("t3_tick_const", 32'(t3), 32'h3f);

    // Freeze at counter 2 with divisor 4
    step(1'b1, 1'b0, 1'b0, 1'b1, DW'(4));
    run(2);
    hold_clk = bus.clk_out;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      check("t4_frozen_tick", 32'(bus.tick), 32'd0);
      check("t4_frozen_clk", 32'(bus.clk_out), 32'(hold_clk));
    end
    run(3);
    step(1'b1, 1'b0, 1'b0, 1'b1, DW'(6));
    check("t4_frozen_load", 32'(bus.div_cur), 32'd6);
    check("t4_load_keeps_clk", 32'(bus.clk_out), 32'(m_clk));

    // Back-to-back loads (last wins), then clr with a same-cycle load
    run(2);
    step(1'b1, 1'b1, 1'b0, 1'b1, DW'(3));
    step(1'b1, 1'b1, 1'b0, 1'b1, DW'(5));
    step(1'b1, 1'b1, 1'b1, 1'b1, DW'(7));
    check("t5_clr_tick", 32'(bus.tick), 32'd0);
    check("t5_clr_clk", 32'(bus.clk_out), 32'd0);
    check("t5_clr_keeps_div", 32'(bus.div_cur), 32'd6);
    run(8);
    check("t5_pending_applied", 32'(bus.div_cur), 32'd5);
    // Load exactly on a terminal count
    while (m_cnt != m_div - DW'(1)) run(1);
    step(1'b1, 1'b1, 1'b0, 1'b1, DW'(3));
    check("t5_tc_load", 32'(bus.div_cur), 32'd3);
    run(2);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("t5_rst_div", 32'(bus.div_cur), 32'(DEF));
    check("t5_rst_clk", 32'(bus.clk_out), 32'd0);

    // Largest divisor: exactly one tick in 256 cycles, on the 255th
    step(1'b1, 1'b0, 1'b0, 1'b1, DW'(255));
    nt = 0;
    for (int c = 1; c <= 256; c++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      if (bus.tick) begin
        nt++;
        check("t_max_tick_cycle", 32'(c), 32'd255);
      end
    end
    check("t_max_tick_count", 32'(nt), 32'd1);

`ifdef TICK_COUNT_EN
    // Tick counter wraps with CNT_WIDTH=2 at divide-by-1
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b1, DW'(1));
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("t6_tick_count", 32'(bus.tick_count), 32'((c + 1) % 4));
    end
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           DW'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
